// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers.
// Each grant covers a burst of up to MAX_BURST words, ended early by req_last.
// FIFO full stalls the burst in the same cycle (zero-latency backpressure).
module fifo_wr_arbiter #(
  parameter  int unsigned N         = 4,
  parameter  int unsigned DW        = 8,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned GW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  output logic            fifo_wr_en,
  output logic [DW-1:0]   fifo_din,
  output logic [GW-1:0]   grant_id,
  output logic            busy
);

  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr, rr_ptr_nxt;
  logic [GW-1:0] grant_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [GW-1:0] pick;
  logic          pick_vld;
  logic          xfer;
  logic          sel_valid;
  logic          sel_last;
  logic [DW-1:0] sel_data;

  // Round-robin search starting just after the last served requester
  always_comb begin
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % N;
      if (req_valid[GW'(idx)]) begin
        pick     = GW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Granted requester's signals and the transfer condition
  always_comb begin
    sel_valid = req_valid[grant_id];
    sel_last  = req_last[grant_id];
    sel_data  = req_data[int'(grant_id)*DW +: DW];
    xfer      = (state == BURST) && sel_valid && !fifo_full;
  end

  // Next-state logic and write-port outputs
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    beat_nxt   = beat_cnt;
    fifo_wr_en = 1'b0;
    req_ready  = '0;
    fifo_din   = '0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick;
          beat_nxt  = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        busy       = 1'b1;
        fifo_din   = sel_data;
        fifo_wr_en = xfer;
        if (xfer) begin
          req_ready = N'(1) << grant_id;
          beat_nxt  = beat_cnt + BW'(1);
          if (sel_last || (beat_cnt == BW'(MAX_BURST - 1))) begin
            rr_ptr_nxt = grant_id;
            beat_nxt   = '0;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, grant and beat registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= GW'(N - 1);
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
      beat_cnt <= beat_nxt;
    end
  end

endmodule
